// File: rtl/tuser_in_fsm_if.sv
// Ingress AXI-Stream beat bus as seen by the tuple input stage.
// The stage only observes the stream, so the slave side is all inputs.
interface tuser_in_fsm_if #(
    parameter int TUSER_WIDTH = 128
);
    logic                   tin_avalid;
    logic                   tin_aready;
    logic                   tin_tlast;
    logic [TUSER_WIDTH-1:0] tin_atuser;

    modport master (
        output tin_avalid,
        output tin_aready,
        output tin_tlast,
        output tin_atuser
    );

    modport slave (
        input tin_avalid,
        input tin_aready,
        input tin_tlast,
        input tin_atuser
    );
endinterface

// File: rtl/tuser_in_fsm.sv
// Tuple input stage: captures tuser metadata on the SOP beat of every
// ingress packet and strobes it to the tuple input, tracking framing,
// per-packet beat count (saturating) and completed packets (wrapping).
// Passive observer of the stream; never applies backpressure.
module tuser_in_fsm #(
    parameter int TUSER_WIDTH    = 128,
    parameter int BEAT_CNT_WIDTH = 16,
    parameter int PKT_CNT_WIDTH  = 32
) (
    input  logic                      tin_aclk,
    input  logic                      tin_arst,
    tuser_in_fsm_if.slave             s_axis,
    output logic                      tin_valid,
    output logic [TUSER_WIDTH-1:0]    tin_data,
    output logic                      tin_sop,
    output logic                      tin_eop,
    output logic [BEAT_CNT_WIDTH-1:0] tin_beats,
    output logic [PKT_CNT_WIDTH-1:0]  tin_pkt_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t                    state_q;
    logic [BEAT_CNT_WIDTH-1:0] beat_q;
    logic [BEAT_CNT_WIDTH-1:0] beat_d;
    logic                      valid_q;
    logic                      sop_q;
    logic                      eop_q;
    logic [TUSER_WIDTH-1:0]    data_q;
    logic [BEAT_CNT_WIDTH-1:0] beats_q;
    logic [PKT_CNT_WIDTH-1:0]  pkt_q;
    logic                      xfer;

    // Only accepted beats matter; tlast/tuser on idle cycles are ignored.
    assign xfer = s_axis.tin_avalid && s_axis.tin_aready;

    // Saturating beat count including the beat now being transferred.
    always_comb begin
        beat_d = beat_q;
        if (beat_q != '1) begin
            beat_d = beat_q + BEAT_CNT_WIDTH'(1);
        end
    end

    // Framing FSM with registered strobes, metadata and counters.
    always_ff @(posedge tin_aclk) begin
        if (tin_arst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            data_q  <= '0;
            beats_q <= '0;
            pkt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            if (xfer) begin
                case (state_q)
                    IDLE: begin
                        data_q  <= s_axis.tin_atuser;
                        valid_q <= 1'b1;
                        sop_q   <= 1'b1;
                        if (s_axis.tin_tlast) begin
                            // single-beat packet: open and close together
                            eop_q   <= 1'b1;
                            beats_q <= BEAT_CNT_WIDTH'(1);
                            pkt_q   <= pkt_q + PKT_CNT_WIDTH'(1);
                            beat_q  <= '0;
                        end else begin
                            beat_q  <= BEAT_CNT_WIDTH'(1);
                            state_q <= PKT;
                        end
                    end
                    PKT: begin
                        if (s_axis.tin_tlast) begin
                            beats_q <= beat_d;
                            eop_q   <= 1'b1;
                            pkt_q   <= pkt_q + PKT_CNT_WIDTH'(1);
                            beat_q  <= '0;
                            state_q <= IDLE;
                        end else begin
                            beat_q  <= beat_d;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tin_valid   = valid_q;
    assign tin_sop     = sop_q;
    assign tin_eop     = eop_q;
    assign tin_data    = data_q;
    assign tin_beats   = beats_q;
    assign tin_pkt_cnt = pkt_q;

endmodule

// File: tb/tb_tuser_in_fsm.sv
// Directed bench for tuser_in_fsm: a default-width instance and a narrow
// counter instance (4-bit beat/packet counters) see the same stream.
module tb_tuser_in_fsm;

    localparam int TW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          avalid, aready, tlast;
    logic [TW-1:0] atuser;

    logic          a_valid, a_sop, a_eop;
    logic [TW-1:0] a_data;
    logic [15:0]   a_beats;
    logic [31:0]   a_pkt;

    logic          b_valid, b_sop, b_eop;
    logic [TW-1:0] b_data;
    logic [3:0]    b_beats;
    logic [3:0]    b_pkt;

    int pass_cnt = 0;
    int total    = 0;

    logic [TW-1:0] A5, FF;

    always #5 clk = ~clk;

    tuser_in_fsm_if #(.TUSER_WIDTH(TW)) axis_a ();
    tuser_in_fsm_if #(.TUSER_WIDTH(TW)) axis_b ();

    assign axis_a.tin_avalid = avalid;
    assign axis_a.tin_aready = aready;
    assign axis_a.tin_tlast  = tlast;
    assign axis_a.tin_atuser = atuser;
    assign axis_b.tin_avalid = avalid;
    assign axis_b.tin_aready = aready;
    assign axis_b.tin_tlast  = tlast;
    assign axis_b.tin_atuser = atuser;

    tuser_in_fsm #(.TUSER_WIDTH(TW)) dut_a (
        .tin_aclk(clk), .tin_arst(rst), .s_axis(axis_a.slave),
        .tin_valid(a_valid), .tin_data(a_data), .tin_sop(a_sop),
        .tin_eop(a_eop), .tin_beats(a_beats), .tin_pkt_cnt(a_pkt)
    );

    tuser_in_fsm #(.TUSER_WIDTH(TW), .BEAT_CNT_WIDTH(4), .PKT_CNT_WIDTH(4)) dut_b (
        .tin_aclk(clk), .tin_arst(rst), .s_axis(axis_b.slave),
        .tin_valid(b_valid), .tin_data(b_data), .tin_sop(b_sop),
        .tin_eop(b_eop), .tin_beats(b_beats), .tin_pkt_cnt(b_pkt)
    );

    task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Apply one cycle of stream inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic v, input logic r, input logic l, input logic [TW-1:0] u);
        avalid = v; aready = r; tlast = l; atuser = u;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        A5 = {16{8'hA5}};
        FF = '1;
        rst = 1'b1;
        avalid = 0; aready = 0; tlast = 0; atuser = '0;
        @(posedge clk); #1;
        idle();
        chk("rst_valid", a_valid, 0);
        chk("rst_sop",   a_sop, 0);
        chk("rst_eop",   a_eop, 0);
        chk("rst_data",  a_data, 0);
        chk("rst_beats", a_beats, 0);
        chk("rst_pkt",   a_pkt, 0);
        rst = 1'b0;

        // 4-beat packet, A5 metadata on SOP, FF afterwards
        cyc(1, 1, 0, A5);
        chk("p4_valid", a_valid, 1);
        chk("p4_sop",   a_sop, 1);
        chk("p4_data",  a_data, A5);
        cyc(1, 1, 0, FF);
        chk("p4_valid_once", a_valid, 0);
        chk("p4_sop_once",   a_sop, 0);
        cyc(1, 1, 0, FF);
        chk("p4_data_hold",  a_data, A5);
        cyc(1, 1, 1, FF);
        chk("p4_eop",   a_eop, 1);
        chk("p4_beats", a_beats, 4);
        chk("p4_pkt",   a_pkt, 1);
        chk("p4_data_end", a_data, A5);
        idle();
        chk("p4_eop_once", a_eop, 0);

        // same packet with ready toggling and tlast shown on non-beats
        cyc(1, 1, 0, A5);
        chk("tg_valid", a_valid, 1);
        cyc(1, 0, 1, FF);
        chk("tg_no_eop1", a_eop, 0);
        cyc(1, 1, 0, FF);
        cyc(1, 0, 1, '0);
        chk("tg_no_eop2", a_eop, 0);
        cyc(1, 1, 0, FF);
        cyc(1, 0, 1, 128'h1234);
        chk("tg_no_eop3", a_eop, 0);
        chk("tg_no_valid", a_valid, 0);
        cyc(1, 1, 1, FF);
        chk("tg_eop",   a_eop, 1);
        chk("tg_beats", a_beats, 4);
        chk("tg_pkt",   a_pkt, 2);
        chk("tg_data",  a_data, A5);

        // three single-beat packets back to back
        cyc(1, 1, 1, 128'h1);
        chk("sb1_valid", a_valid, 1);
        chk("sb1_eop",   a_eop, 1);
        chk("sb1_data",  a_data, 128'h1);
        cyc(1, 1, 1, 128'h2);
        chk("sb2_valid", a_valid, 1);
        chk("sb2_data",  a_data, 128'h2);
        cyc(1, 1, 1, 128'h3);
        chk("sb3_valid", a_valid, 1);
        chk("sb3_data",  a_data, 128'h3);
        chk("sb3_pkt",   a_pkt, 5);
        chk("sb3_beats", a_beats, 1);

        // stalled stream: valid without ready for 10 cycles, tlast high
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 1, 128'hBAD);
            chk("stall_strobes", {a_valid, a_sop, a_eop}, 0);
        end
        chk("stall_pkt",   a_pkt, 5);
        chk("stall_beats", a_beats, 1);
        chk("stall_data",  a_data, 128'h3);

        // reset mid-packet (after beat 2 of 5); beat during reset is dropped
        cyc(1, 1, 0, 128'h11);
        cyc(1, 1, 0, 128'h12);
        rst = 1'b1;
        cyc(1, 1, 0, 128'hDEAD);
        chk("mr_valid", a_valid, 0);
        chk("mr_data",  a_data, 0);
        chk("mr_beats", a_beats, 0);
        chk("mr_pkt",   a_pkt, 0);
        chk("mr_flags", {a_sop, a_eop}, 0);
        rst = 1'b0;
        cyc(1, 1, 0, 128'h13);
        chk("mr_sop",   a_sop, 1);
        chk("mr_data3", a_data, 128'h13);
        cyc(1, 1, 0, 128'h14);
        cyc(1, 1, 1, 128'h15);
        chk("mr_eop",    a_eop, 1);
        chk("mr_beats3", a_beats, 3);
        chk("mr_pkt1",   a_pkt, 1);
        chk("mr_data_h", a_data, 128'h13);

        // saturation and wrap: 20-beat packet, then 16 single-beat packets
        rst = 1'b1;
        idle();
        rst = 1'b0;
        cyc(1, 1, 0, 128'h77);
        for (int i = 0; i < 18; i++) cyc(1, 1, 0, FF);
        cyc(1, 1, 1, FF);
        chk("sat_a_beats", a_beats, 20);
        chk("sat_b_beats", b_beats, 15);
        chk("sat_b_pkt",   b_pkt, 1);
        chk("sat_b_data",  b_data, 128'h77);
        for (int i = 0; i < 16; i++) cyc(1, 1, 1, TW'(i + 100));
        chk("wrap_a_pkt",   a_pkt, 17);
        chk("wrap_b_pkt",   b_pkt, 1);
        chk("wrap_b_beats", b_beats, 1);
        chk("wrap_b_data",  b_data, 128'd115);
        idle();
        chk("wrap_end_strobes", {b_valid, b_sop, b_eop}, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/tuser_in_fsm.md
# tuser_in_fsm

Ingress-side counterpart of the tuple output stage: watches the AXI-Stream beats entering the P4 pipeline and extracts per-packet metadata from `tin_atuser` on the first beat of every packet. It presents the metadata to the SDNet tuple input as a single-cycle `tin_valid` strobe with `tin_data` held stable. It also tracks packet framing (SOP/EOP), counts beats per packet and counts completed packets for debug. It sits between the ingress AXIS port and the SDNet tuple input, in parallel with the data path, and never stalls the stream.

## Interface
Parameters:
- TUSER_WIDTH, 128, width of `tin_atuser` and `tin_data`
- BEAT_CNT_WIDTH, 16, width of the per-packet beat counter (saturating)
- PKT_CNT_WIDTH, 32, width of the completed-packet counter (wrapping)

Ports:
- `tin_aclk`  in  1  clock; everything is on the rising edge
- `tin_arst`  in  1  reset, synchronous, active-high
- `tin_avalid`  in  1  AXIS beat valid
- `tin_aready`  in  1  AXIS beat ready, observed only; a beat transfers when `tin_avalid && tin_aready`
- `tin_tlast`  in  1  last beat of packet
- `tin_atuser`  in  TUSER_WIDTH  metadata; meaningful on the SOP beat only
- `tin_valid`  out  1  one-cycle tuple strobe
- `tin_data`  out  TUSER_WIDTH  captured metadata; held until the next SOP
- `tin_sop`  out  1  one-cycle strobe, registered copy of "SOP beat transferred"
- `tin_eop`  out  1  one-cycle strobe, registered copy of "EOP beat transferred"
- `tin_beats`  out  BEAT_CNT_WIDTH  beat count of the last completed packet; updated with `tin_eop`
- `tin_pkt_cnt`  out  PKT_CNT_WIDTH  completed packets since reset

## Operation
- Beat: a cycle with `tin_avalid=1` and `tin_aready=1`. Cycles that are not beats are ignored entirely, whatever `tin_tlast` or `tin_atuser` show.
- States: IDLE (expecting SOP), PKT (inside a multi-beat packet).
- IDLE, beat, `tin_tlast=0`:
  - latch `tin_atuser` into `tin_data`
  - pulse `tin_valid` and `tin_sop`
  - internal beat count := 1
  - go to PKT
- IDLE, beat, `tin_tlast=1` (single-beat packet):
  - latch `tin_data`
  - pulse `tin_valid`, `tin_sop` and `tin_eop`
  - `tin_beats` := 1
  - `tin_pkt_cnt` += 1
  - stay in IDLE
- PKT, beat, `tin_tlast=0`:
  - beat count += 1, saturating at all-ones
  - `tin_atuser` ignored
- PKT, beat, `tin_tlast=1`:
  - `tin_beats` := beat count + 1 (saturating)
  - pulse `tin_eop`
  - `tin_pkt_cnt` += 1
  - go to IDLE
- No beat: state and counters unchanged; strobes deasserted.
- `tin_pkt_cnt` wraps from all-ones to 0.
- `tin_beats` saturates at 2^BEAT_CNT_WIDTH−1.
- Reset (any state, including mid-packet):
  - state := IDLE
  - all outputs 0 (`tin_valid`, `tin_sop`, `tin_eop`, `tin_data`, `tin_beats`, `tin_pkt_cnt`)
  - beat count := 0
  - The first beat after reset is treated as SOP even if it is physically mid-packet. This is the required behaviour; there is no resynchronisation logic.

## Timing
- All outputs are registered.
- Latency: an SOP beat in cycle N gives `tin_valid`/`tin_sop` = 1 in cycle N+1, and `tin_data` takes the new value in cycle N+1.
- An EOP beat in cycle N gives `tin_eop` = 1 in cycle N+1, with `tin_beats` and `tin_pkt_cnt` updated in cycle N+1.
- Strobes are high for exactly one cycle per event.
- Back-to-back packets (EOP in cycle N, SOP in cycle N+1) give `tin_eop` in cycle N+1 and `tin_valid` in cycle N+2, with no lost packet.
- Consecutive single-beat packets on consecutive cycles give `tin_valid`=1 on consecutive cycles, each with its own `tin_data`.
- `tin_data` never changes except on a cycle where `tin_valid`=1, or on reset.
- Reset asserted during the same cycle as a beat: reset wins and the beat is dropped.

## Test plan
- Reset, then a 4-beat packet with `tin_atuser`=0xA5A5…A5 on beat 1 and 0xFF…FF on beats 2–4 -> `tin_valid` exactly 1 cycle after beat 1, `tin_data`=0xA5A5…A5 held through the end, `tin_eop` 1 cycle after beat 4, `tin_beats`=4, `tin_pkt_cnt`=1.
- Same packet with `tin_aready` toggling 0/1 and `tin_tlast`=1 while `tin_aready`=0 -> only accepted beats count; `tin_beats`=4; no early `tin_eop`.
- Three single-beat packets on consecutive cycles with tuser 0x1, 0x2, 0x3 -> `tin_valid`=1 for 3 consecutive cycles with `tin_data`=0x1, 0x2, 0x3; `tin_pkt_cnt`=3; `tin_beats`=1.
- Reset asserted after beat 2 of a 5-beat packet, then beats 3–5 sent -> all outputs 0 during reset; beat 3 is taken as SOP (`tin_data` = beat-3 tuser); `tin_beats`=3; `tin_pkt_cnt`=1.
- BEAT_CNT_WIDTH=4, 20-beat packet -> `tin_beats`=15. PKT_CNT_WIDTH=4, 17 packets -> `tin_pkt_cnt`=1.
- `tin_avalid`=1, `tin_aready`=0 for 10 cycles with `tin_tlast`=1 -> no strobes, counters unchanged.
